// File: rtl/xy_input_port_if.sv
// Handshake and status bundle between an xy_input_port and its neighbours.
// Latency: none, this is wiring only.
// Backpressure: in_ready gates the input side; out_ready grants the routed output.
interface xy_input_port_if #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [4:0]       out_valid;
    logic [4:0]       out_ready;
    logic             drop_pulse;
    logic [7:0]       drop_cnt;
    logic [CW-1:0]    occupancy;

    // port view taken by the input port block itself
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, drop_pulse, drop_cnt, occupancy
    );

    // view taken by whatever feeds the port and consumes its routed output
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, drop_pulse, drop_cnt, occupancy
    );
endinterface

// File: rtl/xy_input_port.sv
// Buffered mesh-router input port: FIFO, then a registered Y-first/X-second route stage.
// Latency: a packet pushed into an empty port is presented one edge later.
// Backpressure: in_ready drops when the FIFO is full; a held packet waits for its out_ready bit.

// Generic circular-buffer FIFO with a combinational head read.
// Latency: a pushed word is visible at the head after the push edge.
// Backpressure: the caller must not push when full or pop when empty.
module xy_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign rd_dat = mem[rd_ptr];

    // storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module xy_input_port #(
    parameter int WIDTH   = 39,
    parameter int AW      = 4,
    parameter int X_LSB   = 33,
    parameter int Y_LSB   = 29,
    parameter int X_LOCAL = 1,
    parameter int Y_LOCAL = 1,
    parameter int IN_DIR  = 0,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    xy_input_port_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} st_t;

    st_t              state;
    st_t              state_nxt;
    logic [WIDTH-1:0] head;
    logic [CW-1:0]    count;
    logic             push;
    logic             load;
    logic             xfer;
    logic             fifo_ne;
    logic [2:0]       dir;
    logic [4:0]       dir_oh;
    logic             dir_drop;
    logic [WIDTH-1:0] rt_data;
    logic [4:0]       rt_oh;
    logic             rt_drop;
    logic [7:0]       drop_cnt;
    logic [AW-1:0]    dst_x;
    logic [AW-1:0]    dst_y;

    // ready depends only on stored fill level, never on out_ready
    assign bus.in_ready  = ~rst & (count != FULL);
    assign push          = bus.in_valid & bus.in_ready;
    assign fifo_ne       = (count != '0);
    assign bus.occupancy = count;
    assign bus.out_data  = rt_data;
    assign bus.drop_cnt  = drop_cnt;

    xy_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_dat (bus.in_data),
        .pop    (load),
        .rd_dat (head),
        .count  (count)
    );

    assign dst_x = head[X_LSB +: AW];
    assign dst_y = head[Y_LSB +: AW];

    // Y-first then X routing of the FIFO head; a U-turn back out the arrival port is dropped
    always_comb begin
        dir = 3'd2;
        if (dst_x == AW'(X_LOCAL) && dst_y == AW'(Y_LOCAL)) begin
            dir = 3'd4;
        end else if (dst_y > AW'(Y_LOCAL)) begin
            dir = 3'd1;
        end else if (dst_y < AW'(Y_LOCAL)) begin
            dir = 3'd0;
        end else if (dst_x > AW'(X_LOCAL)) begin
            dir = 3'd3;
        end
        dir_oh   = 5'b00001 << dir;
        dir_drop = (dir == 3'(IN_DIR));
    end

    // route stage state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // next state: a dropped packet always frees the stage; a granted packet may be replaced at once
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (fifo_ne) state_nxt = HOLD;
            HOLD: begin
                if (rt_drop) begin
                    state_nxt = EMPTY;
                end else if (xfer) begin
                    state_nxt = fifo_ne ? HOLD : EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // outputs: one-hot request unless the held packet is a drop, plus the FIFO pop
    always_comb begin
        bus.out_valid  = 5'b00000;
        bus.drop_pulse = 1'b0;
        if (state == HOLD) begin
            if (rt_drop) begin
                bus.drop_pulse = 1'b1;
            end else begin
                bus.out_valid = rt_oh;
            end
        end
        xfer = |(bus.out_valid & bus.out_ready);
        load = fifo_ne & ((state == EMPTY) | ((state == HOLD) & ~rt_drop & xfer));
    end

    // route register captures the popped head together with its routing decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rt_data <= '0;
            rt_oh   <= '0;
            rt_drop <= 1'b0;
        end else if (load) begin
            rt_data <= head;
            rt_oh   <= dir_oh;
            rt_drop <= dir_drop;
        end
    end

    // saturating drop counter, bumped as the dropped packet enters the stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (load && dir_drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_xy_input_port.sv
// Directed bench for xy_input_port: reset, routing, drops, backpressure, full-with-pop.
// Latency: checks the one-edge push-to-request delay.
// Backpressure: exercises in_ready deassertion and per-direction grants.
module tb_xy_input_port;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    xy_input_port_if #(.WIDTH(39), .DEPTH(4)) bus ();
    xy_input_port_if #(.WIDTH(39), .DEPTH(4)) bus2 ();

    xy_input_port #(.IN_DIR(0)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    xy_input_port #(.IN_DIR(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [38:0] mk(input logic [3:0] x, input logic [3:0] y, input logic [28:0] pl);
        return {2'b00, x, y, pl};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // push n local-bound packets with payloads base..base+n-1, bounded wait
    task automatic push_n(input int n, input int base);
        int i;
        i = 0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 60 && i < n; c++) begin
            logic fire;
            bus.in_data = mk(4'd1, 4'd1, 29'(base + i));
            fire = bus.in_ready;
            step();
            if (fire) i++;
        end
        bus.in_valid = 1'b0;
        check("push_n_done", 64'(i), 64'(n));
    endtask

    // present one packet with out_ready low, expect the given request next edge, then grant it
    task automatic route_one(input string tag, input logic [38:0] p, input logic [4:0] exp);
        bus.out_ready = 5'b00000;
        bus.in_data   = p;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        check({tag, "_occ"}, 64'(bus.occupancy), 64'd1);
        check({tag, "_early"}, 64'(bus.out_valid), 64'd0);
        step();
        check({tag, "_vld"}, 64'(bus.out_valid), 64'(exp));
        check({tag, "_dat"}, 64'(bus.out_data), 64'(p));
        bus.out_ready = ~exp;
        step();
        check({tag, "_hold"}, 64'(bus.out_valid), 64'(exp));
        bus.out_ready = exp;
        step();
        check({tag, "_gone"}, 64'(bus.out_valid), 64'd0);
        bus.out_ready = 5'b00000;
    endtask

    initial begin
        int  acc;
        bit  any_v;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.in_data = '0;  bus.in_valid = 1'b0;  bus.out_ready = '0;
        bus2.in_data = '0; bus2.in_valid = 1'b0; bus2.out_ready = '0;
        repeat (3) step();
        check("rst_ready", 64'(bus.in_ready), 64'd0);
        check("rst_vld", 64'(bus.out_valid), 64'd0);
        check("rst_dat", 64'(bus.out_data), 64'd0);
        check("rst_occ", 64'(bus.occupancy), 64'd0);
        check("rst_dcnt", 64'(bus.drop_cnt), 64'd0);
        check("rst_dpulse", 64'(bus.drop_pulse), 64'd0);
        rst = 1'b0;
        #1;
        check("rel_ready", 64'(bus.in_ready), 64'd1);

        // local delivery and the Y-first / X-second routes
        route_one("local", mk(4'd1, 4'd1, 29'h00E0508), 5'b10000);
        route_one("right", mk(4'd3, 4'd1, 29'h0000123), 5'b01000);
        route_one("down",  mk(4'd0, 4'd2, 29'h0000456), 5'b00010);
        route_one("left",  mk(4'd0, 4'd1, 29'h0000789), 5'b00100);

        // y below local on the port that arrived from below goes up
        bus2.in_data  = mk(4'd1, 4'd0, 29'h0000ABC);
        bus2.in_valid = 1'b1;
        step();
        bus2.in_valid = 1'b0;
        step();
        check("up_vld", 64'(bus2.out_valid), 64'b00001);
        check("up_dat", 64'(bus2.out_data), 64'(mk(4'd1, 4'd0, 29'h0000ABC)));

        // U-turn drop: arrived from up, routed up
        bus.out_ready = 5'b11111;
        bus.in_data   = mk(4'd1, 4'd0, 29'h0000001);
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        check("drop_pre", 64'(bus.drop_pulse), 64'd0);
        step();
        check("drop_vld", 64'(bus.out_valid), 64'd0);
        check("drop_pulse", 64'(bus.drop_pulse), 64'd1);
        check("drop_cnt1", 64'(bus.drop_cnt), 64'd1);
        step();
        check("drop_pulse_end", 64'(bus.drop_pulse), 64'd0);
        check("drop_cnt1_hold", 64'(bus.drop_cnt), 64'd1);

        // 299 more drops saturate the counter
        acc   = 1;
        any_v = 1'b0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3000 && acc < 300; c++) begin
            logic fire;
            fire = bus.in_ready;
            step();
            if (fire) acc++;
            if (bus.out_valid != 5'b0) any_v = 1'b1;
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 100 && (bus.occupancy != 0 || bus.drop_pulse); c++) begin
            step();
            if (bus.out_valid != 5'b0) any_v = 1'b1;
        end
        step();
        check("drop_accepts", 64'(acc), 64'd300);
        check("drop_sat", 64'(bus.drop_cnt), 64'd255);
        check("drop_no_vld", 64'(any_v), 64'd0);

        // reset mid-stream discards queued packets
        bus.out_ready = 5'b00000;
        push_n(3, 16);
        check("pre_rst_occ", 64'(bus.occupancy), 64'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_vld", 64'(bus.out_valid), 64'd0);
        check("mid_rst_occ", 64'(bus.occupancy), 64'd0);
        check("mid_rst_ready", 64'(bus.in_ready), 64'd0);
        check("mid_rst_dcnt", 64'(bus.drop_cnt), 64'd0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 5'b11111;
        any_v = 1'b0;
        repeat (8) begin
            step();
            if (bus.out_valid != 5'b0) any_v = 1'b1;
        end
        check("post_rst_quiet", 64'(any_v), 64'd0);

        // backpressure: one held plus DEPTH queued, then full rate drain in order
        bus.out_ready = 5'b00000;
        push_n(5, 32);
        check("bp_occ", 64'(bus.occupancy), 64'd4);
        check("bp_ready", 64'(bus.in_ready), 64'd0);
        check("bp_vld", 64'(bus.out_valid), 64'b10000);
        check("bp_head", 64'(bus.out_data), 64'(mk(4'd1, 4'd1, 29'd32)));
        bus.out_ready = 5'b11111;
        for (int i = 1; i < 5; i++) begin
            step();
            check("bp_drain_vld", 64'(bus.out_valid), 64'b10000);
            check("bp_drain_dat", 64'(bus.out_data), 64'(mk(4'd1, 4'd1, 29'(32 + i))));
        end
        step();
        check("bp_empty", 64'(bus.out_valid), 64'd0);

        // full FIFO with a pop in the same cycle still refuses the push
        bus.out_ready = 5'b00000;
        push_n(5, 64);
        bus.in_data   = mk(4'd1, 4'd1, 29'd99);
        bus.in_valid  = 1'b1;
        bus.out_ready = 5'b11111;
        check("fp_ready0", 64'(bus.in_ready), 64'd0);
        step();
        check("fp_occ_a", 64'(bus.occupancy), 64'd3);
        check("fp_ready1", 64'(bus.in_ready), 64'd1);
        check("fp_dat_a", 64'(bus.out_data), 64'(mk(4'd1, 4'd1, 29'd65)));
        step();
        bus.in_valid = 1'b0;
        check("fp_occ_b", 64'(bus.occupancy), 64'd3);
        check("fp_dat_b", 64'(bus.out_data), 64'(mk(4'd1, 4'd1, 29'd66)));
        step();
        check("fp_dat_c", 64'(bus.out_data), 64'(mk(4'd1, 4'd1, 29'd67)));
        step();
        check("fp_dat_d", 64'(bus.out_data), 64'(mk(4'd1, 4'd1, 29'd68)));
        step();
        check("fp_dat_e", 64'(bus.out_data), 64'(mk(4'd1, 4'd1, 29'd99)));
        check("fp_vld_e", 64'(bus.out_valid), 64'b10000);
        step();
        check("fp_done", 64'(bus.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
